// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage MIPS core.
//
//   The block captures the decoded operands and control from ID on each rising
//   edge. It resolves operand forwarding from EX/MEM and MEM/WB, and it drives
//   the ALU operands and ALU control directly. It also detects load-use hazards
//   (Stall holds PC and IF/ID) and inserts a bubble into EX on a stall, on a
//   branch flush, or when ID holds no valid instruction.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   IdValid .. IdMemToReg decoded instruction from ID (data, register numbers,
//                         ALU control, control bits)
//   Flush                 branch taken in EX; squash the instruction in ID
//   MemRegWrite/MemRd/MemALUResult   EX/MEM forwarding source
//   WbRegWrite/WbRd/WbData           MEM/WB forwarding and write-through source
//   FirstOperand          ALU operand A (forwarded rs)
//   SecondOperand         ALU operand B (immediate or forwarded rt)
//   ALUcontrolinput       registered ALU operation code
//   ExStoreData           forwarded rt, used as store data
//   ExDest                registered destination register number
//   ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg   registered control
//   Stall                 load-use hazard; hold PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IdValid,
    input  logic [DATA_W-1:0] IdRsData,
    input  logic [DATA_W-1:0] IdRtData,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [REG_W-1:0]  IdRs,
    input  logic [REG_W-1:0]  IdRt,
    input  logic [REG_W-1:0]  IdRd,
    input  logic              IdUsesRt,
    input  logic [3:0]        IdALUcontrol,
    input  logic              IdALUSrc,
    input  logic              IdRegDst,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdMemToReg,
    input  logic              Flush,
    input  logic              MemRegWrite,
    input  logic [REG_W-1:0]  MemRd,
    input  logic [DATA_W-1:0] MemALUResult,
    input  logic              WbRegWrite,
    input  logic [REG_W-1:0]  WbRd,
    input  logic [DATA_W-1:0] WbData,
    output logic [DATA_W-1:0] FirstOperand,
    output logic [DATA_W-1:0] SecondOperand,
    output logic [3:0]        ALUcontrolinput,
    output logic [DATA_W-1:0] ExStoreData,
    output logic [REG_W-1:0]  ExDest,
    output logic              ExValid,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic              ExMemWrite,
    output logic              ExMemToReg,
    output logic              Stall
);

    // Registered operand state that is not directly visible on a port.
    logic              ex_alu_src;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;

    logic              load_bubble;
    logic [DATA_W-1:0] cap_rs_data;
    logic [DATA_W-1:0] cap_rt_data;
    logic [DATA_W-1:0] fwd_rt;

    // A load in EX whose destination feeds the instruction in ID cannot be
    // forwarded in time, so the stage holds ID for one cycle. A flush kills
    // the ID instruction anyway, so the flush suppresses the stall.
    assign Stall = ExValid & ExMemRead & (ExDest != '0) & IdValid & ~Flush &
                   ((ExDest == IdRs) | (IdUsesRt & (ExDest == IdRt)));

    assign load_bubble = Flush | Stall | ~IdValid;

    // The register file is written in WB in the same cycle that ID reads it.
    // Take the value being written so the captured operand is not stale.
    assign cap_rs_data = (WbRegWrite && (WbRd != '0) && (WbRd == IdRs)) ? WbData : IdRsData;
    assign cap_rt_data = (WbRegWrite && (WbRd != '0) && (WbRd == IdRt)) ? WbData : IdRtData;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values no matter how the blocks are ordered.
    // NOTE: the data registers are reset as well, even though a bubble may
    // leave them holding stale values. A reset must never let an old operand
    // reach the ALU outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ExValid         <= 1'b0;
            ExRegWrite      <= 1'b0;
            ExMemRead       <= 1'b0;
            ExMemWrite      <= 1'b0;
            ExMemToReg      <= 1'b0;
            ALUcontrolinput <= 4'd0;
            ExDest          <= '0;
            ex_alu_src      <= 1'b0;
            ex_rs           <= '0;
            ex_rt           <= '0;
            ex_rs_data      <= '0;
            ex_rt_data      <= '0;
            ex_imm          <= '0;
        end else if (load_bubble) begin
            // Only the bits that cause architectural side effects are cleared.
            // The operand fields keep their old values and are ignored.
            ExValid    <= 1'b0;
            ExRegWrite <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExMemToReg <= 1'b0;
        end else begin
            ExValid         <= 1'b1;
            ExRegWrite      <= IdRegWrite;
            ExMemRead       <= IdMemRead;
            ExMemWrite      <= IdMemWrite;
            ExMemToReg      <= IdMemToReg;
            ALUcontrolinput <= IdALUcontrol;
            ExDest          <= IdRegDst ? IdRd : IdRt;
            ex_alu_src      <= IdALUSrc;
            ex_rs           <= IdRs;
            ex_rt           <= IdRt;
            ex_rs_data      <= cap_rs_data;
            ex_rt_data      <= cap_rt_data;
            ex_imm          <= IdImm;
        end
    end

    // Forwarding: the youngest producer (EX/MEM) wins over MEM/WB. Register 0
    // is hard-wired to zero and is never forwarded.
    // NOTE: each output gets its default value first, so no path through the
    // block leaves an output unassigned and no latch is inferred.
    always_comb begin
        FirstOperand = ex_rs_data;
        fwd_rt       = ex_rt_data;

        if (MemRegWrite && (MemRd != '0) && (MemRd == ex_rs)) begin
            FirstOperand = MemALUResult;
        end else if (WbRegWrite && (WbRd != '0) && (WbRd == ex_rs)) begin
            FirstOperand = WbData;
        end

        if (MemRegWrite && (MemRd != '0) && (MemRd == ex_rt)) begin
            fwd_rt = MemALUResult;
        end else if (WbRegWrite && (WbRd != '0) && (WbRd == ex_rt)) begin
            fwd_rt = WbData;
        end
    end

    assign SecondOperand = ex_alu_src ? ex_imm : fwd_rt;
    assign ExStoreData   = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. Directed scenarios cover reset, basic
//   capture, forwarding priority, the load-use stall, flush, register 0,
//   write-through and asynchronous reset. A randomized run is checked against
//   a behavioural model of the instruction held in EX.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          IdValid;
    logic [DW-1:0] IdRsData, IdRtData, IdImm;
    logic [RW-1:0] IdRs, IdRt, IdRd;
    logic          IdUsesRt;
    logic [3:0]    IdALUcontrol;
    logic          IdALUSrc, IdRegDst, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
    logic          Flush;
    logic          MemRegWrite;
    logic [RW-1:0] MemRd;
    logic [DW-1:0] MemALUResult;
    logic          WbRegWrite;
    logic [RW-1:0] WbRd;
    logic [DW-1:0] WbData;
    logic [DW-1:0] FirstOperand, SecondOperand, ExStoreData;
    logic [3:0]    ALUcontrolinput;
    logic [RW-1:0] ExDest;
    logic          ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Stall;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IdValid(IdValid), .IdRsData(IdRsData), .IdRtData(IdRtData), .IdImm(IdImm),
        .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd), .IdUsesRt(IdUsesRt),
        .IdALUcontrol(IdALUcontrol), .IdALUSrc(IdALUSrc), .IdRegDst(IdRegDst),
        .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
        .IdMemToReg(IdMemToReg), .Flush(Flush),
        .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemALUResult(MemALUResult),
        .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
        .FirstOperand(FirstOperand), .SecondOperand(SecondOperand),
        .ALUcontrolinput(ALUcontrolinput), .ExStoreData(ExStoreData), .ExDest(ExDest),
        .ExValid(ExValid), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg), .Stall(Stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        IdValid = 0; IdRsData = 0; IdRtData = 0; IdImm = 0;
        IdRs = 0; IdRt = 0; IdRd = 0; IdUsesRt = 0; IdALUcontrol = 0;
        IdALUSrc = 0; IdRegDst = 0; IdRegWrite = 0; IdMemRead = 0;
        IdMemWrite = 0; IdMemToReg = 0; Flush = 0;
        MemRegWrite = 0; MemRd = 0; MemALUResult = 0;
        WbRegWrite = 0; WbRd = 0; WbData = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw into register 'dst' (base register 1)
    task automatic drive_lw(input logic [RW-1:0] dst);
        drive_idle();
        IdValid = 1; IdRs = 1; IdRt = dst; IdRegDst = 0; IdALUSrc = 1;
        IdImm = 32'h8; IdALUcontrol = 4'd2; IdMemRead = 1; IdRegWrite = 1; IdMemToReg = 1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic          valid, regwrite, memread, memwrite, memtoreg, alusrc;
        logic [3:0]    aluctl;
        logic [RW-1:0] dest, rs, rt;
        logic [DW-1:0] rsval, rtval, imm;
    } ex_model_t;

    // Value of register r as EX sees it: the youngest in-flight producer wins.
    function automatic logic [DW-1:0] exp_fwd(input logic [RW-1:0] r, input logic [DW-1:0] stored);
        if (r == 0) return stored;
        if (MemRegWrite && MemRd == r) return MemALUResult;
        if (WbRegWrite && WbRd == r) return WbData;
        return stored;
    endfunction

    // Value the register file effectively returns in ID when WB writes it in the same cycle.
    function automatic logic [DW-1:0] exp_read(input logic [RW-1:0] r, input logic [DW-1:0] rf);
        if (r != 0 && WbRegWrite && WbRd == r) return WbData;
        return rf;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0;
        drive_idle();
        IdValid = 1; IdRs = 3; IdRt = 3; IdRsData = $urandom; IdMemRead = 1; IdRegWrite = 1;
        MemRegWrite = 1; MemRd = 3; MemALUResult = $urandom;
        #3;
        n_cmp++;
        if ({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ALUcontrolinput, ExDest,
             FirstOperand, SecondOperand, ExStoreData} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%0b ctl=%0h dest=%0d a=%h b=%h sd=%h required all 0",
                     ExValid, ALUcontrolinput, ExDest, FirstOperand, SecondOperand, ExStoreData);
        end
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b required 0", Stall); end
        tick();
        n_cmp++;
        if ({ExValid, ExRegWrite, ExMemRead, ALUcontrolinput, ExDest} !== '0) begin
            n_err++;
            $display("FAIL reset_held_through_edge: valid=%0b rw=%0b mr=%0b required 0",
                     ExValid, ExRegWrite, ExMemRead);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        drive_idle();
        IdValid = 1; IdRs = 1; IdRt = 2; IdRd = 3; IdRegDst = 1; IdRegWrite = 1;
        IdRsData = 5; IdRtData = 7; IdALUcontrol = 4'd2; IdALUSrc = 0; IdUsesRt = 1;
        tick();
        n_cmp++;
        if ({FirstOperand, SecondOperand, ALUcontrolinput, ExValid, ExDest, ExRegWrite}
            !== {32'd5, 32'd7, 4'd2, 1'b1, 5'd3, 1'b1}) begin
            n_err++;
            $display("FAIL basic_capture: a=%0d b=%0d ctl=%0d valid=%0b dest=%0d rw=%0b required 5 7 2 1 3 1",
                     FirstOperand, SecondOperand, ALUcontrolinput, ExValid, ExDest, ExRegWrite);
        end
        // Immediate operand, rt as destination; store data still carries rt.
        IdALUSrc = 1; IdImm = 32'h1234; IdRegDst = 0; IdRt = 9; IdRtData = 32'hBEEF; IdALUcontrol = 4'd7;
        tick();
        n_cmp++;
        if ({SecondOperand, ExStoreData, ExDest, ALUcontrolinput} !== {32'h1234, 32'hBEEF, 5'd9, 4'd7}) begin
            n_err++;
            $display("FAIL basic_immediate: b=%h sd=%h dest=%0d ctl=%0d required 1234 beef 9 7",
                     SecondOperand, ExStoreData, ExDest, ALUcontrolinput);
        end
    endtask

    task automatic test_forwarding();
        drive_idle();
        IdValid = 1; IdRs = 3; IdRt = 5; IdRsData = 32'hAAAA; IdRtData = 32'h55; IdUsesRt = 1;
        tick();
        IdValid = 0;
        MemRegWrite = 1; MemRd = 3; MemALUResult = 32'h10;
        WbRegWrite = 1; WbRd = 3; WbData = 32'h20;
        #1;
        n_cmp++;
        if (FirstOperand !== 32'h10) begin
            n_err++; $display("FAIL fwd_mem_priority: got %h required 00000010", FirstOperand);
        end
        MemRegWrite = 0;
        #1;
        n_cmp++;
        if (FirstOperand !== 32'h20) begin
            n_err++; $display("FAIL fwd_wb: got %h required 00000020", FirstOperand);
        end
        WbRegWrite = 0;
        #1;
        n_cmp++;
        if (FirstOperand !== 32'hAAAA) begin
            n_err++; $display("FAIL fwd_none: got %h required 0000aaaa", FirstOperand);
        end
        MemRegWrite = 1; MemRd = 5; MemALUResult = 32'h77;
        #1;
        n_cmp++;
        if ({SecondOperand, ExStoreData, FirstOperand} !== {32'h77, 32'h77, 32'hAAAA}) begin
            n_err++;
            $display("FAIL fwd_rt: b=%h sd=%h a=%h required 77 77 aaaa", SecondOperand, ExStoreData, FirstOperand);
        end
    endtask

    task automatic test_load_use();
        drive_lw(5'd4);
        tick();
        drive_idle();
        IdValid = 1; IdRs = 4; IdRt = 2; IdRd = 7; IdRegDst = 1; IdRegWrite = 1;
        IdUsesRt = 1; IdALUcontrol = 4'd2; IdRsData = 32'h11; IdRtData = 32'h22;
        #1;
        n_cmp++;
        if (Stall !== 1'b1) begin n_err++; $display("FAIL loaduse_stall: got %0b required 1", Stall); end
        tick();
        n_cmp++;
        if ({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Stall} !== 6'b0) begin
            n_err++;
            $display("FAIL loaduse_bubble: valid=%0b rw=%0b mr=%0b mw=%0b m2r=%0b stall=%0b required all 0",
                     ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Stall);
        end
        tick();
        n_cmp++;
        if ({ExValid, ExDest, ExRegWrite, ExMemRead, FirstOperand} !== {1'b1, 5'd7, 1'b1, 1'b0, 32'h11}) begin
            n_err++;
            $display("FAIL loaduse_resume: valid=%0b dest=%0d rw=%0b mr=%0b a=%h required 1 7 1 0 11",
                     ExValid, ExDest, ExRegWrite, ExMemRead, FirstOperand);
        end
        // An rt match only counts when the instruction actually reads rt.
        drive_lw(5'd4);
        tick();
        drive_idle();
        IdValid = 1; IdRs = 1; IdRt = 4; IdUsesRt = 0;
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL loaduse_rt_unused: got %0b required 0", Stall); end
        IdUsesRt = 1;
        #1;
        n_cmp++;
        if (Stall !== 1'b1) begin n_err++; $display("FAIL loaduse_rt_used: got %0b required 1", Stall); end
        tick();
    endtask

    task automatic test_flush();
        drive_lw(5'd4);
        tick();
        drive_idle();
        IdValid = 1; IdRs = 4; IdRt = 4; IdUsesRt = 1; IdRegWrite = 1; IdMemWrite = 1; Flush = 1;
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %0b required 0", Stall); end
        tick();
        n_cmp++;
        if ({ExValid, ExRegWrite, ExMemWrite, ExMemRead} !== 4'b0) begin
            n_err++;
            $display("FAIL flush_bubble: valid=%0b rw=%0b mw=%0b mr=%0b required all 0",
                     ExValid, ExRegWrite, ExMemWrite, ExMemRead);
        end
        Flush = 0;
        tick();
        n_cmp++;
        if ({ExValid, ExMemWrite} !== 2'b11) begin
            n_err++; $display("FAIL flush_resume: valid=%0b mw=%0b required 1 1", ExValid, ExMemWrite);
        end
    endtask

    task automatic test_reg_zero();
        drive_idle();
        IdValid = 1; IdRs = 0; IdRt = 0; WbRegWrite = 1; WbRd = 0; WbData = 32'h77;
        tick();
        MemRegWrite = 1; MemRd = 0; MemALUResult = 32'hDEAD;
        #1;
        n_cmp++;
        if ({FirstOperand, ExStoreData} !== 64'd0) begin
            n_err++; $display("FAIL reg0_no_forward: a=%h sd=%h required 0 0", FirstOperand, ExStoreData);
        end
        MemRegWrite = 0;
        IdRs = 6; IdRt = 6; IdRsData = 32'h1; IdRtData = 32'h2; IdUsesRt = 1;
        WbRegWrite = 1; WbRd = 6; WbData = 32'h99;
        tick();
        WbRegWrite = 0; IdValid = 0;
        #1;
        n_cmp++;
        if ({FirstOperand, ExStoreData} !== {32'h99, 32'h99}) begin
            n_err++; $display("FAIL write_through: a=%h sd=%h required 99 99", FirstOperand, ExStoreData);
        end
    endtask

    task automatic test_async_reset();
        drive_idle();
        IdValid = 1; IdRs = 2; IdRsData = 32'hCAFE; IdALUcontrol = 4'd7; IdRd = 8; IdRegDst = 1; IdRegWrite = 1;
        tick();
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({ExValid, ExRegWrite, ALUcontrolinput, ExDest, FirstOperand, SecondOperand, Stall} !== '0) begin
            n_err++;
            $display("FAIL async_reset: valid=%0b rw=%0b ctl=%0d dest=%0d a=%h required all 0",
                     ExValid, ExRegWrite, ALUcontrolinput, ExDest, FirstOperand);
        end
        #2;
        rst_n = 1;
        tick();
        n_cmp++;
        if ({ExValid, FirstOperand, ALUcontrolinput, ExDest} !== {1'b1, 32'hCAFE, 4'd7, 5'd8}) begin
            n_err++;
            $display("FAIL reset_release_capture: valid=%0b a=%h ctl=%0d dest=%0d required 1 cafe 7 8",
                     ExValid, FirstOperand, ALUcontrolinput, ExDest);
        end
    endtask

    task automatic test_random();
        ex_model_t m;
        logic          exp_stall;
        logic [DW-1:0] exp_a, exp_rt, exp_b;
        logic [3:0]    ops [6];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6; ops[4] = 4'd7; ops[5] = 4'd12;
        drive_idle();
        rst_n = 0;
        #2;
        rst_n = 1;
        m = '{valid: 0, regwrite: 0, memread: 0, memwrite: 0, memtoreg: 0, alusrc: 0,
              aluctl: 0, dest: 0, rs: 0, rt: 0, rsval: 0, rtval: 0, imm: 0};
        for (int i = 0; i < 500; i++) begin
            IdValid      = ($urandom_range(0, 4) != 0);
            Flush        = ($urandom_range(0, 9) == 0);
            IdRs         = RW'($urandom_range(0, 7));
            IdRt         = RW'($urandom_range(0, 7));
            IdRd         = RW'($urandom_range(0, 7));
            IdRsData     = $urandom;
            IdRtData     = $urandom;
            IdImm        = $urandom;
            IdUsesRt     = 1'($urandom_range(0, 1));
            IdALUcontrol = ops[$urandom_range(0, 5)];
            IdALUSrc     = 1'($urandom_range(0, 1));
            IdRegDst     = 1'($urandom_range(0, 1));
            IdRegWrite   = 1'($urandom_range(0, 1));
            IdMemRead    = ($urandom_range(0, 2) == 0);
            IdMemWrite   = 1'($urandom_range(0, 1));
            IdMemToReg   = 1'($urandom_range(0, 1));
            MemRegWrite  = 1'($urandom_range(0, 1));
            MemRd        = RW'($urandom_range(0, 7));
            MemALUResult = $urandom;
            WbRegWrite   = 1'($urandom_range(0, 1));
            WbRd         = RW'($urandom_range(0, 7));
            WbData       = $urandom;
            #1;
            // A load in EX blocks an ID instruction that reads its result.
            exp_stall = m.valid && m.memread && m.dest != 0 && IdValid && !Flush &&
                        (m.dest == IdRs || (IdUsesRt && m.dest == IdRt));
            exp_a  = exp_fwd(m.rs, m.rsval);
            exp_rt = exp_fwd(m.rt, m.rtval);
            exp_b  = m.alusrc ? m.imm : exp_rt;
            n_cmp++;
            if (Stall !== exp_stall) begin
                n_err++; $display("FAIL rand_stall[%0d]: got %0b required %0b", i, Stall, exp_stall);
            end
            n_cmp++;
            if ({FirstOperand, SecondOperand, ExStoreData} !== {exp_a, exp_b, exp_rt}) begin
                n_err++;
                $display("FAIL rand_operands[%0d]: a=%h b=%h sd=%h required %h %h %h",
                         i, FirstOperand, SecondOperand, ExStoreData, exp_a, exp_b, exp_rt);
            end
            n_cmp++;
            if ({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} !==
                {m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg}) begin
                n_err++;
                $display("FAIL rand_control[%0d]: got %b required %b", i,
                         {ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg},
                         {m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg});
            end
            if (m.valid) begin
                n_cmp++;
                if ({ALUcontrolinput, ExDest} !== {m.aluctl, m.dest}) begin
                    n_err++;
                    $display("FAIL rand_ctl_dest[%0d]: ctl=%0d dest=%0d required %0d %0d",
                             i, ALUcontrolinput, ExDest, m.aluctl, m.dest);
                end
            end
            @(posedge clk);
            if (Flush || exp_stall || !IdValid) begin
                // Nothing enters EX: no side effects, operand fields left as they were.
                m.valid = 0; m.regwrite = 0; m.memread = 0; m.memwrite = 0; m.memtoreg = 0;
            end else begin
                m.valid = 1; m.regwrite = IdRegWrite; m.memread = IdMemRead;
                m.memwrite = IdMemWrite; m.memtoreg = IdMemToReg; m.alusrc = IdALUSrc;
                m.aluctl = IdALUcontrol; m.dest = IdRegDst ? IdRd : IdRt;
                m.rs = IdRs; m.rt = IdRt; m.imm = IdImm;
                m.rsval = exp_read(IdRs, IdRsData);
                m.rtval = exp_read(IdRt, IdRtData);
            end
            #1;
        end
    endtask

    initial begin
        rst_n = 0;
        drive_idle();
        test_reset();
        test_basic();
        test_forwarding();
        test_load_use();
        test_flush();
        test_reg_zero();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
